mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Shares one 4:1 WIDTH-bit mux between four valid/ready requesters.
- Round-robin arbitration picks a source. The block drives the mux select, then registers the selected data into a single-entry output stage with valid/ready handshake.
- Sits between four producer channels and one consumer. It is the sequencing and control wrapper for the 4:1 case-based data mux.

Parameters:
- WIDTH, 4, data width of each requester channel and of the output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  4  bit i: requester i presents data.
- in_data0  input  WIDTH  requester 0 data.
- in_data1  input  WIDTH  requester 1 data.
- in_data2  input  WIDTH  requester 2 data.
- in_data3  input  WIDTH  requester 3 data.
- in_ready  output  4  bit i: requester i transfer accepted this cycle (one-hot or zero).
- out_valid  output  1  output stage holds a word.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  2  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (rst_n=0, immediate and asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer last=3, so requester 0 has first priority.
  - in_ready=0 while in reset.
- State: single output register; two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Slot free: free = !out_valid || out_ready.
- Arbitration (combinational):
  - Search order is last+1, last+2, last+3, last (mod 4).
  - Grant g is the first i in that order with in_valid[i]=1.
  - No grant if in_valid=0.
- Ready: in_ready[i] = free && grant_valid && (g==i).
  - in_ready depends combinationally on in_valid and out_ready. Requesters must not make in_valid depend on in_ready.
- Load (rising edge when free && |in_valid):
  - out_data <= in_data[g]: the case-style mux, sel=g.
  - out_sel <= g; out_valid <= 1; last <= g.
- Drain only (out_valid && out_ready && in_valid==0): out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_valid, out_data, out_sel, last hold. in_ready=0.
- Simultaneous drain and load in the same cycle: new word replaces old. out_valid stays 1, giving full throughput of one word per cycle.
- Latency: an accepted word appears on out_data one cycle after its in_valid/in_ready handshake.
- Fairness:
  - Any continuously asserted requester is granted within 4 loads.
  - The pointer advances only on a load. Stalls never change priority.
- Requester rule: a requester with in_valid=1 and in_ready=0 must hold in_valid and data stable. The arbiter re-evaluates every cycle.
- X handling: in_data of non-granted requesters may be X. out_data must not be affected by them.
- Reset mid-operation: a held word is discarded, the pointer returns to 3, and no in_ready pulse occurs during reset.

Test Plan:
- Reset, then in_valid=0001, in_data0=A, out_ready=1 -> in_ready=0001 that cycle; next cycle out_valid=1, out_data=A, out_sel=0.
- in_valid=1111, data A,B,C,D, out_ready=1 held 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle.
- Load data 5 from requester 2, then out_ready=0 for 3 cycles with in_valid=1111 -> out_data=5, out_sel=2 stable, in_ready=0000. After out_ready=1, the next grant is 3.
- in_valid=1010, pointer last=1 -> grant 3 first, then 1, then 3. Requesters 0 and 2 get no in_ready.
- in_data3='x, in_valid=0001, data0=7 -> out_data=7 with no X. Then in_valid=1000 -> out_data=X propagates only when sel=3.
- Mid-transfer with out_valid=1, assert rst_n=0 asynchronously between edges -> out_valid=0 and out_data=0 immediately. After release with in_valid=1111, the first grant is 0.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if
// Bundles the four requester channels and the single consumer channel of the
// round-robin 4:1 mux arbiter.
//   in_valid[3:0]  requester i presents data
//   in_data0..3    requester data words
//   in_ready[3:0]  requester i transfer accepted this cycle (one-hot or zero)
//   out_valid      output stage holds a word
//   out_data       registered selected data
//   out_sel        index of the requester that supplied out_data
//   out_ready      consumer accepts the word
// Modports: slave = arbiter side, master = producers/consumer side.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter wrapped around a 4:1 WIDTH-bit data mux. The granted
// requester's word is captured in a single-entry output register with a
// valid/ready handshake; a drain and a load in the same cycle give one word
// per cycle throughput.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux4_rr_arbiter_if.slave (requester and consumer channels)
module mux4_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [1:0]       out_sel_reg, out_sel_next;
    logic [1:0]       last_reg, last_next;

    logic [1:0]       cand_idx [4];
    logic [3:0]       cand_hit;
    logic [1:0]       grant;
    logic             grant_valid;
    logic             free;
    logic             load;
    logic [WIDTH-1:0] mux_data;
    logic [3:0]       in_ready_w;

    // Candidate k is the requester checked k-th after the last winner; the
    // 2-bit add wraps so the last winner itself is checked last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
            assign cand_hit[gi] = bus.in_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant       = cand_idx[0];
        grant_valid = |cand_hit;
        if (cand_hit[0])      grant = cand_idx[0];
        else if (cand_hit[1]) grant = cand_idx[1];
        else if (cand_hit[2]) grant = cand_idx[2];
        else                  grant = cand_idx[3];
    end

    // Only the granted channel reaches the register, so unknown data on
    // idle requesters cannot leak into out_data.
    always_comb begin
        mux_data = bus.in_data0;
        case (grant)
            2'd0:    mux_data = bus.in_data0;
            2'd1:    mux_data = bus.in_data1;
            2'd2:    mux_data = bus.in_data2;
            default: mux_data = bus.in_data3;
        endcase
    end

    assign free = (state_reg == EMPTY) || bus.out_ready;
    assign load = free && grant_valid;

    // rst_n gates in_ready so no requester sees an accept while in reset.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            assign in_ready_w[gi] = rst_n && load && (grant == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        out_data_next = out_data_reg;
        out_sel_next  = out_sel_reg;
        last_next     = last_reg;
        case (state_reg)
            EMPTY: begin
                if (load) begin
                    state_next    = FULL;
                    out_data_next = mux_data;
                    out_sel_next  = grant;
                    last_next     = grant;
                end
            end
            FULL: begin
                if (load) begin
                    // Drain and reload together: the new word replaces the old.
                    out_data_next = mux_data;
                    out_sel_next  = grant;
                    last_next     = grant;
                end else if (bus.out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            out_data_reg <= '0;
            out_sel_reg  <= 2'd0;
            last_reg     <= 2'd3;
        end else begin
            state_reg    <= state_next;
            out_data_reg <= out_data_next;
            out_sel_reg  <= out_sel_next;
            last_reg     <= last_next;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_reg == FULL);
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
    localparam int W = 4;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    word_t exp_q[$];

    mux4_rr_arbiter_if #(.WIDTH(W)) bus ();

    mux4_rr_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.in_valid = 4'b0000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        bus.in_data0 = d0;
        bus.in_data1 = d1;
        bus.in_data2 = d2;
        bus.in_data3 = d3;
    endtask

    task automatic test_reset;
        word_t w;
        rst_n = 1'b0;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        set_data(4'hA, 4'hB, 4'hC, 4'hD);
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h sel=%0d, want valid=0 data=0 sel=0",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        n_checks++;
        if (bus.in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, want 0000", bus.in_ready);
        end
        rst_n = 1'b1;
        bus.in_valid = 4'b0001;
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b, want 0001", bus.in_ready);
        end
        w.sel = 2'd0; w.data = 4'hA; exp_q.push_back(w);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_word: scoreboard empty");
        end else begin
            w = exp_q.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data) begin
                n_fail++;
                $display("FAIL single_word: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                         bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
            end
        end
        $display("txn single: sel=%0d data=%h", bus.out_sel, bus.out_data);
        bus.in_valid = 4'b0000;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hA || bus.out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL drain_only: got valid=%b data=%h sel=%0d, want valid=0 data=a sel=0",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
    endtask

    task automatic test_back_to_back;
        word_t w;
        logic [W-1:0] dv [4];
        dv[0] = 4'hA; dv[1] = 4'hB; dv[2] = 4'hC; dv[3] = 4'hD;
        do_reset();
        set_data(dv[0], dv[1], dv[2], dv[3]);
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            w.sel = 2'(k % 4);
            w.data = dv[k % 4];
            n_checks++;
            if (bus.in_ready !== (4'b0001 << w.sel)) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b, want %b", k, bus.in_ready, 4'b0001 << w.sel);
            end
            exp_q.push_back(w);
            tick();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: scoreboard empty", k);
            end else begin
                w = exp_q.pop_front();
                if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data) begin
                    n_fail++;
                    $display("FAIL b2b_word[%0d]: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                             k, bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
                end
            end
            $display("txn b2b %0d: sel=%0d data=%h", k, bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_stall;
        word_t w;
        do_reset();
        set_data(4'h1, 4'h2, 4'h5, 4'h8);
        bus.in_valid = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        w.sel = 2'd2; w.data = 4'h5; exp_q.push_back(w);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stall_load: scoreboard empty");
        end else begin
            w = exp_q.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data) begin
                n_fail++;
                $display("FAIL stall_load: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                         bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
            end
        end
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b, want 0000", k, bus.in_ready);
            end
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== 4'h5) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b sel=%0d data=%h, want valid=1 sel=2 data=5",
                         k, bus.out_valid, bus.out_sel, bus.out_data);
            end
            $display("txn stall %0d: sel=%0d data=%h", k, bus.out_sel, bus.out_data);
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_resume_ready: got %b, want 1000", bus.in_ready);
        end
        w.sel = 2'd3; w.data = 4'h8; exp_q.push_back(w);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stall_resume_word: scoreboard empty");
        end else begin
            w = exp_q.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data) begin
                n_fail++;
                $display("FAIL stall_resume_word: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                         bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
            end
        end
        $display("txn resume: sel=%0d data=%h", bus.out_sel, bus.out_data);
    endtask

    task automatic test_sparse;
        word_t w;
        logic [1:0] seq [4];
        // Pointer starts at 3; a lone request from 1 moves it to 1.
        seq[0] = 2'd1; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd3;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = (k == 0) ? 4'b0010 : 4'b1010;
            #1;
            w.sel = seq[k];
            w.data = (seq[k] == 2'd1) ? 4'h2 : 4'h8;
            n_checks++;
            if (bus.in_ready !== (4'b0001 << w.sel)) begin
                n_fail++;
                $display("FAIL sparse_ready[%0d]: got %b, want %b", k, bus.in_ready, 4'b0001 << w.sel);
            end
            exp_q.push_back(w);
            tick();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sparse_word[%0d]: scoreboard empty", k);
            end else begin
                w = exp_q.pop_front();
                if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data) begin
                    n_fail++;
                    $display("FAIL sparse_word[%0d]: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                             k, bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
                end
            end
            $display("txn sparse %0d: sel=%0d data=%h", k, bus.out_sel, bus.out_data);
        end
    endtask

    task automatic test_x_data;
        word_t w;
        bus.in_data0 = 4'h7;
        bus.in_data3 = 'x;
        bus.in_valid = 4'b0001;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL xdata_ready: got %b, want 0001", bus.in_ready);
        end
        w.sel = 2'd0; w.data = 4'h7; exp_q.push_back(w);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL xdata_word: scoreboard empty");
        end else begin
            w = exp_q.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data
                || $isunknown(bus.out_data)) begin
                n_fail++;
                $display("FAIL xdata_word: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                         bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
            end
        end
        $display("txn xdata: sel=%0d data=%h", bus.out_sel, bus.out_data);
        bus.in_data3 = 4'h9;
        bus.in_valid = 4'b1000;
        #1;
        w.sel = 2'd3; w.data = 4'h9; exp_q.push_back(w);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sel3_word: scoreboard empty");
        end else begin
            w = exp_q.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data) begin
                n_fail++;
                $display("FAIL sel3_word: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                         bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
            end
        end
        $display("txn sel3: sel=%0d data=%h", bus.out_sel, bus.out_data);
    endtask

    task automatic test_reset_mid;
        word_t w;
        // Pointer is 3 here, so this load comes from requester 0 and moves it to 0.
        set_data(4'hA, 4'hB, 4'hC, 4'hD);
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 4'b0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%b data=%h sel=%0d, want valid=0 data=0 sel=0",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        n_checks++;
        if (bus.in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b, want 0000", bus.in_ready);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL postreset_ready: got %b, want 0001", bus.in_ready);
        end
        w.sel = 2'd0; w.data = 4'hA; exp_q.push_back(w);
        tick();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL postreset_word: scoreboard empty");
        end else begin
            w = exp_q.pop_front();
            if (bus.out_valid !== 1'b1 || bus.out_sel !== w.sel || bus.out_data !== w.data) begin
                n_fail++;
                $display("FAIL postreset_word: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                         bus.out_valid, bus.out_sel, bus.out_data, w.sel, w.data);
            end
        end
        $display("txn postreset: sel=%0d data=%h", bus.out_sel, bus.out_data);
    endtask

    initial begin
        bus.in_valid = 4'b0000;
        bus.out_ready = 1'b0;
        set_data(4'h0, 4'h0, 4'h0, 4'h0);
        test_reset();
        test_back_to_back();
        test_stall();
        test_sparse();
        test_x_data();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
